// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants, state encoding and queue entry layout for the instruction fetch unit.
// Latency and backpressure are not applicable here; these are types and constants only.
package instr_fetch_unit_pkg;

    localparam int          DEF_ADDR_W   = 5;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Redirect targets are word aligned; the low two bits are ignored.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, inst} FIFO between fetch and decode; the head is readable in the same cycle.
// Push on full is accepted only alongside a pop; flush overrides both push and pop.
module fetch_queue
    import instr_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign head  = empty ? '0 : r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // When full, the write slot is the head slot being popped this cycle.
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Owns the PC and feeds decode through a 2-entry queue; one instruction per cycle when decode is ready.
// The PC holds while the queue is full; a redirect flushes the queue and a zero word halts fetch.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    logic [31:0]      r_pc;
    fetch_state_t     r_state;
    logic             r_halted;
    logic [CNT_W-1:0] r_fetch_count;

    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic         w_pop;
    logic         w_slot;
    logic         w_zero;
    logic         w_push;
    logic         w_halt;

    // A redirect cycle discards the pop and never pushes.
    assign w_pop  = !w_empty && out_ready && !redirect_valid;
    assign w_slot = (r_state == FETCH) && !redirect_valid && (!w_full || w_pop);
    assign w_zero = (im_inst == HALT_WORD);
    assign w_push = w_slot && !w_zero;
    assign w_halt = w_slot && w_zero;

    assign w_push_entry = '{pc: r_pc, inst: im_inst};

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_state       <= FETCH;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect_valid) begin
            r_pc     <= align_pc(redirect_pc);
            r_state  <= FETCH;
            r_halted <= 1'b0;
        end else if (w_halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
        end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
            if (r_fetch_count != {CNT_W{1'b1}}) begin
                r_fetch_count <= r_fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign im_addr     = r_pc[ADDR_W+1:2];
    assign out_valid   = !w_empty;
    assign out_inst    = w_head.inst;
    assign out_pc      = w_head.pc;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_instr_fetch_unit;

    localparam int AW = 5;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_inst;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          halted;
    logic [CW-1:0] fetch_count;

    logic [31:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign im_inst = mem[im_addr];

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .im_addr        (im_addr),
        .im_inst        (im_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Reference model: a list of pending (pc, inst) pairs plus the next PC to fetch.
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    bit          m_halted;
    int          m_cnt;

    logic [78:0] dut_vec;
    assign dut_vec = {out_valid, out_pc, out_inst, halted, fetch_count, im_addr};

    function automatic logic [78:0] exp_vec();
        logic        v;
        logic [31:0] p;
        logic [31:0] n;
        logic [7:0]  c;
        logic [4:0]  a;
        v = (m_q.size() > 0);
        p = v ? m_q[0][63:32] : 32'h0;
        n = v ? m_q[0][31:0]  : 32'h0;
        c = 8'(m_cnt);
        a = 5'((m_pc / 4) % 32);
        return {v, p, n, m_halted, c, a};
    endfunction

    task automatic model_step();
        logic [31:0] w;
        if (reset) begin
            m_q.delete();
            m_pc     = 32'h0;
            m_halted = 0;
            m_cnt    = 0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc     = (redirect_pc / 4) * 4;
            m_halted = 0;
        end else begin
            w = mem[(m_pc / 4) % 32];
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (!m_halted && m_q.size() < 2) begin
                if (w == 32'h0) begin
                    m_halted = 1;
                end else begin
                    m_q.push_back({m_pc, w});
                    m_pc = m_pc + 32'd4;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== {1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", dut_vec, {1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 5'd0});
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h00, 32'h04, 32'h08};
        ins = '{32'h00300413, 32'h00100493, 32'h01000913};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({out_valid, out_pc, out_inst, fetch_count} !== {1'b1, pcs[k], ins[k], 8'(k + 1)}) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h cnt=%0d want pc=%h inst=%h cnt=%0d",
                         k, out_valid, out_pc, out_inst, fetch_count, pcs[k], ins[k], k + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, 32'h00300413} ||
                (k >= 1 && im_addr !== 5'd2)) begin
                n_fail++;
                $display("FAIL hold_%0d: got v=%b pc=%h inst=%h addr=%0d want pc=0 inst=00300413 addr=2",
                         k, out_valid, out_pc, out_inst, im_addr);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h04, 32'h00100493}) begin
            n_fail++;
            $display("FAIL release_0: got pc=%h inst=%h want pc=04 inst=00100493", out_pc, out_inst);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h08, 32'h01000913}) begin
            n_fail++;
            $display("FAIL release_1: got pc=%h inst=%h want pc=08 inst=01000913", out_pc, out_inst);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target, input logic [31:0] exp_pc,
                               input logic [31:0] exp_inst, input string name);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_gap: got out_valid=%b pc=%h want out_valid=0", name, out_valid, out_pc);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, exp_pc, exp_inst}) begin
            n_fail++;
            $display("FAIL %s_first: got v=%b pc=%h inst=%h want pc=%h inst=%h",
                     name, out_valid, out_pc, out_inst, exp_pc, exp_inst);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b1;
        repeat (4) tick();
        redirect_to(32'h34, 32'h34, 32'h01228863, "redirect");
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h38, 32'h005282b3}) begin
            n_fail++;
            $display("FAIL redirect_second: got pc=%h inst=%h want pc=38 inst=005282b3", out_pc, out_inst);
        end
    endtask

    task automatic test_halt();
        do_reset();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h78;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({out_valid, halted, im_addr} !== {1'b0, 1'b0, 5'd30}) begin
            n_fail++;
            $display("FAIL halt_enter: got v=%b halted=%b addr=%0d want v=0 halted=0 addr=30",
                     out_valid, halted, im_addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({out_valid, halted, im_addr} !== {1'b0, 1'b1, 5'd30}) begin
                n_fail++;
                $display("FAIL halt_hold_%0d: got v=%b halted=%b addr=%0d want v=0 halted=1 addr=30",
                         k, out_valid, halted, im_addr);
            end
        end
        redirect_to(32'h44, 32'h44, 32'h000004b3, "unhalt");
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL unhalt_flag: got halted=%b want 0", halted);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        out_ready = 1'b1;
        repeat (2) tick();
        redirect_to(32'h37, 32'h34, 32'h01228863, "misaligned");
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        repeat (3) tick();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h50;
        out_ready      = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, halted, fetch_count, im_addr} !== {1'b0, 1'b0, 8'h0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b halted=%b cnt=%0d addr=%0d want all zero",
                     out_valid, halted, fetch_count, im_addr);
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, 32'h00300413}) begin
            n_fail++;
            $display("FAIL reset_mid_first: got pc=%h inst=%h want pc=0 inst=00300413", out_pc, out_inst);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            redirect_valid = m_halted;
            redirect_pc    = 32'h0;
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL saturate_%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        redirect_valid = 1'b0;
        n_checks++;
        if (fetch_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturate_final: got cnt=%0d want 255", fetch_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0) || (m_halted && $urandom_range(0, 2) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 127)) : $urandom;
            reset          = ($urandom_range(0, 49) == 0);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0000_0013 | (32'(i) << 7) | 32'h0010_0000;
        end
        mem[0]  = 32'h00300413;
        mem[1]  = 32'h00100493;
        mem[2]  = 32'h01000913;
        mem[13] = 32'h01228863;
        mem[14] = 32'h005282b3;
        mem[17] = 32'h000004b3;
        mem[30] = 32'h00000000;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_misaligned();
        test_reset_mid();
        test_saturate();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
